// File: rtl/streamlined_arith_pkg.sv
// Shared definitions for the streamlined multiplier/divider pair: control states,
// default operand width and a two's-complement magnitude helper.
package streamlined_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 64;

  typedef enum logic [2:0] {
    IDLE,
    ITER,
    FIX,
    DONE,
    WAIT_REL
  } state_e;

  // Magnitude of a width-bit two's-complement value held in the low bits of 'value'.
  // The most negative input yields 2^(width-1), which still fits unsigned.
  function automatic logic [MAX_WIDTH-1:0] abs_tc(input logic [MAX_WIDTH-1:0] value,
                                                  input int unsigned        width);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] sign_vec;
    logic [MAX_WIDTH-1:0] mag;
    mask     = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    sign_vec = value >> (width - 1);
    mag      = sign_vec[0] ? (~value + MAX_WIDTH'(1)) : value;
    return mag & mask;
  endfunction

endpackage

// File: rtl/streamlined_multiplier_if.sv
// Start/Done handshake and operand/result bus of the streamlined multiplier.
// STREAMLINED_MULT_SQ_PORTS_EN adds the SQ_Acc / SQ_Count register views.
interface streamlined_multiplier_if
  import streamlined_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 Start_Sig;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic                 Done_Sig;
  logic [2*WIDTH-1:0]   Product;
`ifdef STREAMLINED_MULT_SQ_PORTS_EN
  logic [2*WIDTH:0]             SQ_Acc;
  logic [$clog2(WIDTH+1)-1:0]   SQ_Count;
`endif

  modport master (
    output Start_Sig, Multiplicand, Multiplier,
    input  Done_Sig, Product
`ifdef STREAMLINED_MULT_SQ_PORTS_EN
    , input SQ_Acc, SQ_Count
`endif
  );

  modport slave (
    input  Start_Sig, Multiplicand, Multiplier,
    output Done_Sig, Product
`ifdef STREAMLINED_MULT_SQ_PORTS_EN
    , output SQ_Acc, SQ_Count
`endif
  );

endinterface

// File: rtl/streamlined_multiplier.sv
// Sequential shift-and-add signed multiplier, one partial product per clock.
// STREAMLINED_MULT_SQ_PORTS_EN exposes the accumulator and step counter.
module streamlined_multiplier
  import streamlined_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  streamlined_multiplier_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e               state_q;
  logic [CW-1:0]        count_q;
  logic [2*WIDTH:0]     acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic                 is_neg_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     mag_a_d;
  logic [WIDTH-1:0]     mag_b_d;
  logic [WIDTH:0]       upper_sum_d;
  logic [2*WIDTH:0]     acc_d;
  logic [2*WIDTH-1:0]   product_d;
  logic                 last_step_d;

  // Upper half is WIDTH+1 bits so the carry of the add survives the shift.
  always_comb begin
    mag_a_d     = WIDTH'(abs_tc(MAX_WIDTH'(bus.Multiplicand), WIDTH));
    mag_b_d     = WIDTH'(abs_tc(MAX_WIDTH'(bus.Multiplier), WIDTH));
    upper_sum_d = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_d       = {upper_sum_d, acc_q[WIDTH-1:0]} >> 1;
    product_d   = is_neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    last_step_d = (count_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      is_neg_q  <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Start_Sig) begin
            is_neg_q <= bus.Multiplicand[WIDTH-1] ^ bus.Multiplier[WIDTH-1];
            mcand_q  <= mag_a_d;
            acc_q    <= {{(WIDTH+1){1'b0}}, mag_b_d};
            count_q  <= '0;
            state_q  <= ITER;
          end
        end
        ITER: begin
          if (!bus.Start_Sig) begin
            state_q <= IDLE;
          end else begin
            acc_q   <= acc_d;
            count_q <= count_q + CW'(1);
            if (last_step_d) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          if (!bus.Start_Sig) begin
            state_q <= IDLE;
          end else begin
            product_q <= product_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        // The pulse always completes; a released Start skips the wait state.
        DONE: begin
          state_q <= bus.Start_Sig ? WAIT_REL : IDLE;
        end
        WAIT_REL: begin
          if (!bus.Start_Sig) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Done_Sig = done_q;
  assign bus.Product  = product_q;
`ifdef STREAMLINED_MULT_SQ_PORTS_EN
  assign bus.SQ_Acc   = acc_q;
  assign bus.SQ_Count = count_q;
`endif

endmodule

// File: tb/tb_streamlined_multiplier.sv
// Self-checking bench for streamlined_multiplier: directed table, abort/reset
// sequences and a randomized sweep against plain signed multiplication.
module tb_streamlined_multiplier;
  import streamlined_arith_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  streamlined_multiplier_if #(.WIDTH(W)) mif ();

  streamlined_multiplier #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (mif)
  );

  int n_total = 0;
  int n_pass  = 0;
  int max_cnt_seen = 0;

  typedef struct {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic [2*W-1:0]      exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Runs one operation with Start_Sig held for 'hold' cycles, cycle 0 being LOAD.
  task automatic do_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                       input int hold, output logic [2*W-1:0] prod,
                       output int dcyc, output int npulse);
    dcyc   = -1;
    npulse = 0;
    prod   = '0;
    @(posedge clk); #1;
    mif.Multiplicand = a;
    mif.Multiplier   = b;
    mif.Start_Sig    = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mif.Multiplicand = W'($urandom);
        mif.Multiplier   = W'($urandom);
      end
      if (mif.Done_Sig) begin
        npulse++;
        if (dcyc < 0) begin
          dcyc = c;
          prod = mif.Product;
        end
      end
`ifdef STREAMLINED_MULT_SQ_PORTS_EN
      if (int'(mif.SQ_Count) > max_cnt_seen) max_cnt_seen = int'(mif.SQ_Count);
`endif
    end
    @(posedge clk); #1;
    mif.Start_Sig = 1'b0;
    @(posedge clk); #1;
    $display("op %0d x %0d -> %h done_cycle=%0d pulses=%0d", a, b, prod, dcyc, npulse);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] prod;
    logic [2*W-1:0] exp16;
    int dcyc, npulse;
    logic signed [W-1:0] ra, rb;

    vecs[0] = '{a: W'(7),    b: W'(9),    exp: 16'h003F};
    vecs[1] = '{a: W'(-3),   b: W'(5),    exp: 16'hFFF1};
    vecs[2] = '{a: W'(5),    b: W'(-3),   exp: 16'hFFF1};
    vecs[3] = '{a: W'(-3),   b: W'(-5),   exp: 16'h000F};
    vecs[4] = '{a: W'(-128), b: W'(-128), exp: 16'h4000};
    vecs[5] = '{a: W'(-128), b: W'(127),  exp: 16'hC080};
    vecs[6] = '{a: W'(0),    b: W'(-77),  exp: 16'h0000};
    vecs[7] = '{a: W'(100),  b: W'(100),  exp: 16'h2710};
    vecs[8] = '{a: W'(2),    b: W'(2),    exp: 16'h0004};

    rst = 1'b1;
    mif.Start_Sig    = 1'b0;
    mif.Multiplicand = '0;
    mif.Multiplier   = '0;
    repeat (2) @(negedge clk);
    check("reset_done", 32'(mif.Done_Sig), 32'd0);
    check("reset_product", 32'(mif.Product), 32'd0);
`ifdef STREAMLINED_MULT_SQ_PORTS_EN
    check("reset_sq_count", 32'(mif.SQ_Count), 32'd0);
    check("reset_sq_acc", 32'(mif.SQ_Acc), 32'd0);
`endif
    rst = 1'b0;

    // Directed table; Start_Sig held 20 cycles to catch any repeated Done_Sig.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, 20, prod, dcyc, npulse);
      check($sformatf("table%0d_product", i), 32'(prod), 32'(vecs[i].exp));
      check($sformatf("table%0d_done_cycle", i), 32'(dcyc), 32'd10);
      check($sformatf("table%0d_pulses", i), 32'(npulse), 32'd1);
    end

    // Abort: 7x9 completes, then 2x2 dropped in cycle 4.
    do_op(W'(7), W'(9), 14, prod, dcyc, npulse);
    check("abort_pre_product", 32'(prod), 32'h003F);
    @(posedge clk); #1;
    mif.Multiplicand = W'(2);
    mif.Multiplier   = W'(2);
    mif.Start_Sig    = 1'b1;
    npulse = 0;
    for (int c = 0; c < 4; c++) @(negedge clk);
    @(posedge clk); #1;
    mif.Start_Sig = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (mif.Done_Sig) npulse++;
    end
    $display("op 2 x 2 aborted in cycle 4 -> product %h pulses=%0d", mif.Product, npulse);
    check("abort_no_done", 32'(npulse), 32'd0);
    check("abort_product_kept", 32'(mif.Product), 32'h003F);
    do_op(W'(2), W'(2), 14, prod, dcyc, npulse);
    check("after_abort_product", 32'(prod), 32'h0004);
    check("after_abort_done_cycle", 32'(dcyc), 32'd10);

    // Start_Sig released during the DONE cycle.
    @(posedge clk); #1;
    mif.Multiplicand = W'(7);
    mif.Multiplier   = W'(9);
    mif.Start_Sig    = 1'b1;
    dcyc = -1;
    for (int c = 0; c < 20 && dcyc < 0; c++) begin
      @(negedge clk);
      if (mif.Done_Sig) begin
        dcyc = c;
        mif.Start_Sig = 1'b0;
      end
    end
    check("drop_in_done_cycle", 32'(dcyc), 32'd10);
    @(negedge clk);
    check("drop_in_done_pulse_width", 32'(mif.Done_Sig), 32'd0);
    $display("op 7 x 9 released in DONE -> done_cycle=%0d", dcyc);
    do_op(W'(-3), W'(-5), 14, prod, dcyc, npulse);
    check("after_drop_product", 32'(prod), 32'h000F);
    check("after_drop_done_cycle", 32'(dcyc), 32'd10);

    // Reset asserted in cycle 5 of 100x100.
    @(posedge clk); #1;
    mif.Multiplicand = W'(100);
    mif.Multiplier   = W'(100);
    mif.Start_Sig    = 1'b1;
    for (int c = 0; c < 5; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_product", 32'(mif.Product), 32'd0);
    check("midreset_done", 32'(mif.Done_Sig), 32'd0);
`ifdef STREAMLINED_MULT_SQ_PORTS_EN
    check("midreset_sq_count", 32'(mif.SQ_Count), 32'd0);
`endif
    $display("op 100 x 100 reset in cycle 5 -> product %h", mif.Product);
    @(negedge clk);
    rst = 1'b0;
    mif.Start_Sig = 1'b0;
    do_op(W'(100), W'(100), 14, prod, dcyc, npulse);
    check("after_reset_product", 32'(prod), 32'h2710);
    check("after_reset_done_cycle", 32'(dcyc), 32'd10);

    // Random sweep against signed integer multiplication.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      exp16 = 16'(int'(ra) * int'(rb));
      do_op(ra, rb, 14, prod, dcyc, npulse);
      check($sformatf("rand%0d_product", i), 32'(prod), 32'(exp16));
      check($sformatf("rand%0d_done_cycle", i), 32'(dcyc), 32'd10);
      check($sformatf("rand%0d_pulses", i), 32'(npulse), 32'd1);
    end

`ifdef STREAMLINED_MULT_SQ_PORTS_EN
    check("sq_count_max", 32'(max_cnt_seen), 32'd8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/streamlined_multiplier.md
Name: streamlined_multiplier

Overview:
- Sequential shift-and-add signed multiplier. It is the inverse companion of the team's streamlined divider.
- Computes the two's-complement product of two WIDTH-bit operands, one partial-product step per clock.
- Uses the same level-held Start_Sig / pulsed Done_Sig handshake as the divider, so the two can share one control FSM in demo top-levels.

Parameters:
- WIDTH, 8, operand width in bits; Product is 2*WIDTH bits; minimum 2.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- Start_Sig  input  1  held high by the requester for the whole operation.
- Multiplicand  input  WIDTH  signed two's-complement operand A, sampled in LOAD.
- Multiplier  input  WIDTH  signed two's-complement operand B, sampled in LOAD.
- Done_Sig  output  1  one-cycle pulse; Product is valid from this cycle on.
- Product  output  2*WIDTH  signed result, registered, held until the next completion.

Behaviour:
- Reset (async, RST=1): state=IDLE, count=0, accumulator=0, isNeg=0, Done_Sig=0, Product=0.
- States: IDLE, ITER, FIX, DONE, WAIT_REL.
- IDLE, when Start_Sig=1 (the LOAD action):
  - isNeg <= A[W-1]^B[W-1].
  - mcand <= |A| as a WIDTH-bit unsigned value, so -2^(W-1) becomes 2^(W-1).
  - acc <= {(WIDTH+1)'b0, |B|}.
  - count <= 0; go to ITER.
- ITER, one step per cycle:
  - If acc[0]=1, add mcand to acc[2W:W], which is WIDTH+1 bits wide to keep the carry.
  - Then shift acc right by 1, filling with 0.
  - count++. After WIDTH steps go to FIX.
- FIX: Product <= isNeg ? -acc[2W-1:0] : acc[2W-1:0]; go to DONE.
- DONE: Done_Sig=1 for exactly this cycle; go to WAIT_REL.
- WAIT_REL: stay until Start_Sig=0, then go to IDLE. A held Start_Sig never triggers a second operation.
- Latency: Start_Sig rises in cycle 0 (LOAD). ITER occupies cycles 1..WIDTH, FIX is WIDTH+1, Done_Sig is high in cycle WIDTH+2. With WIDTH=8, Done_Sig is high in cycle 10.
- Start_Sig dropped in ITER or FIX: abort to IDLE next edge. No Done_Sig. Product keeps its previous value. Internal acc is don't-care.
- Start_Sig dropped in the DONE cycle: Done_Sig still completes its one-cycle pulse, then go to IDLE.
- Operand changes after LOAD are ignored.
- Range: the most negative times the most negative (+2^(2W-2)) fits in 2W signed bits. No overflow is possible; no saturation logic.
- Zero operand: normal latency, Product=0, isNeg is irrelevant since -0=0.
- Reset mid-operation: immediate return to reset values, including Product=0.

Optional Feature:
- Macro: STREAMLINED_MULT_SQ_PORTS_EN.
- Defined: adds debug outputs SQ_Acc [2*WIDTH:0], the live accumulator, and SQ_Count [$clog2(WIDTH+1)-1:0], the step counter. Both are direct register views and read 0 at reset.
- Undefined: these ports do not exist; functional behaviour is identical.

Decomposition:
- Package streamlined_arith_pkg, shared with the divider:
  - state enum typedef (IDLE, ITER, FIX, DONE, WAIT_REL);
  - localparam DEFAULT_WIDTH=8;
  - function abs_tc(value), returning the WIDTH-bit unsigned magnitude.
- No sub-module: the datapath is one adder plus a shifter and stays inline.

Test Plan:
- 7 x 9, Start_Sig held -> Done_Sig high exactly in cycle 10, Product=16'h003F; no second Done_Sig while Start_Sig stays high.
- -3 x 5 -> Product=16'hFFF1 (-15). Then 5 x -3 after a Start_Sig release -> 16'hFFF1. Then -3 x -5 -> 16'h000F.
- -128 x -128 -> 16'h4000. -128 x 127 -> 16'hC080. 0 x -77 -> 16'h0000.
- Complete 7x9=63, then start 2x2 and drop Start_Sig in cycle 4 -> no Done_Sig, Product stays 16'h003F, the next full run gives 16'h0004.
- Assert RST in cycle 5 of 100x100 -> Product=0, Done_Sig=0 asynchronously. After release, 100x100 -> 16'h2710.
- Random signed sweep of 1000 pairs vs a reference model -> exact match every run, Done_Sig pulse width always 1 cycle; repeat with the macro defined, checking SQ_Count reaches 8.
